// File: rtl/uart_programmer_pkg.sv
// Shared constants, state encodings and helpers for the UART programmer.
package uart_programmer_pkg;

    // Command bytes recognised while the protocol FSM is idle
    localparam logic [7:0] CMD_IMEM = 8'h01;
    localparam logic [7:0] CMD_DMEM = 8'h02;
    localparam logic [7:0] CMD_DONE = 8'h03;

    // upg_adr_o layout: bank select above a 14-bit word address
    localparam int BANK_BIT = 14;
    localparam int ADDR_W   = BANK_BIT;

    // Protocol FSM states
    typedef enum logic [2:0] {
        P_IDLE,
        P_LEN_LO,
        P_LEN_HI,
        P_DATA,
        P_WRITE
    } prog_state_e;

    // Receiver FSM states
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    // Clocks per bit, rounded to nearest; below 4 the mid-bit sampling breaks down
    function automatic int calc_div(input int clk_freq, input int baud);
        int div;
        div = (clk_freq + baud / 2) / baud;
        return (div < 4) ? 4 : div;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx_i, samples mid-bit, flags bad stop bits.
module uart_rx
    import uart_programmer_pkg::*;
#(
    parameter int DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       byte_err_o
);

    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIV - 1);

    logic [1:0]       sync_q;
    logic             rx_s;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    // Two-flop synchroniser; resets to the idle-high line level so reset never looks like a start bit
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= 2'b11;
        else      sync_q <= {sync_q[0], rx_i};
    end

    assign rx_s = sync_q[1];

    // Receiver state, baud/bit counters, shift register and output pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Next-state: half a bit to the start-bit centre, then whole bits to each later centre
    // NOTE: every signal gets a default first, so no path through the case can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    // Line back high at the centre means a glitch, not a start bit
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = RX_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    valid_d = rx_s;
                    err_d   = !rx_s;
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_o       = shift_q;
    assign byte_valid_o = valid_q;
    assign byte_err_o   = err_q;

endmodule

// File: rtl/uart_programmer.sv
// UART download loader: turns a command/length/data byte stream into
// 32-bit little-endian word writes on the upg_* port of imem or dmem.
module uart_programmer
    import uart_programmer_pkg::*;
#(
    parameter int CLK_FREQ = 10_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_i,
    output logic        upg_wen_o,
    output logic [14:0] upg_adr_o,
    output logic [31:0] upg_dat_o,
    output logic        upg_done_o,
    output logic        frame_err_o
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;

    prog_state_e       state_q, state_d;
    logic              bank_q, bank_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       len_q, len_d;
    logic [1:0]        idx_q, idx_d;
    logic [31:0]       word_q, word_d;
    logic [14:0]       adr_q, adr_d;
    logic [31:0]       dat_q, dat_d;
    logic              done_q, done_d;
    logic              ferr_q, ferr_d;

    uart_rx #(
        .DIV (DIV)
    ) u_rx (
        .clk          (clk),
        .rst          (rst),
        .rx_i         (rx_i),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_valid),
        .byte_err_o   (rx_err)
    );

    // Protocol state, counters, word buffer and held write-port registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= P_IDLE;
            bank_q  <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            done_q  <= 1'b1;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    // Next-state: decode commands, collect the length, assemble words, issue writes
    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        addr_d  = addr_q;
        len_d   = len_q;
        idx_d   = idx_q;
        word_d  = word_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        done_d  = done_q;
        ferr_d  = ferr_q;
        unique case (state_q)
            P_IDLE: begin
                if (rx_err) begin
                    ferr_d = 1'b1;
                end else if (rx_valid) begin
                    if (rx_byte == CMD_IMEM || rx_byte == CMD_DMEM) begin
                        bank_d  = (rx_byte == CMD_DMEM);
                        addr_d  = '0;
                        done_d  = 1'b0;
                        ferr_d  = 1'b0;
                        state_d = P_LEN_LO;
                    end else if (rx_byte == CMD_DONE) begin
                        done_d = 1'b1;
                    end
                end
            end
            P_LEN_LO: begin
                if (rx_err) begin
                    ferr_d  = 1'b1;
                    state_d = P_IDLE;
                end else if (rx_valid) begin
                    len_d[7:0] = rx_byte;
                    state_d    = P_LEN_HI;
                end
            end
            P_LEN_HI: begin
                if (rx_err) begin
                    ferr_d  = 1'b1;
                    state_d = P_IDLE;
                end else if (rx_valid) begin
                    len_d[15:8] = rx_byte;
                    idx_d       = '0;
                    // A zero-length load just opens the session; done stays low
                    state_d     = ({rx_byte, len_q[7:0]} == 16'd0) ? P_IDLE : P_DATA;
                end
            end
            P_DATA: begin
                if (rx_err) begin
                    ferr_d  = 1'b1;
                    idx_d   = '0;
                    state_d = P_IDLE;
                end else if (rx_valid) begin
                    if (idx_q == 2'd3) begin
                        // Last byte goes straight into the output word so the strobe comes next cycle
                        dat_d            = {rx_byte, word_q[23:0]};
                        adr_d[BANK_BIT]  = bank_q;
                        adr_d[ADDR_W-1:0] = addr_q;
                        idx_d            = '0;
                        state_d          = P_WRITE;
                    end else begin
                        word_d[{idx_q, 3'b000} +: 8] = rx_byte;
                        idx_d                        = idx_q + 2'd1;
                    end
                end
            end
            P_WRITE: begin
                // Address wraps within its bank; the bank bit is never touched here
                addr_d  = addr_q + ADDR_W'(1);
                len_d   = len_q - 16'd1;
                state_d = (len_q == 16'd1) ? P_IDLE : P_DATA;
            end
            default: state_d = P_IDLE;
        endcase
    end

    assign upg_wen_o   = (state_q == P_WRITE);
    assign upg_adr_o   = adr_q;
    assign upg_dat_o   = dat_q;
    assign upg_done_o  = done_q;
    assign frame_err_o = ferr_q;

endmodule

// File: tb/tb_uart_programmer.sv
// Directed bench for uart_programmer at DIV=16 (CLK_FREQ=16, BAUD=1).
module tb_uart_programmer;

    localparam int DIV = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx  = 1'b1;
    logic        upg_wen_o;
    logic [14:0] upg_adr_o;
    logic [31:0] upg_dat_o;
    logic        upg_done_o;
    logic        frame_err_o;

    int total = 0;
    int bad   = 0;

    logic [14:0] wr_adr[$];
    logic [31:0] wr_dat[$];
    logic        wen_prev = 1'b0;
    int          wen_long = 0;

    uart_programmer #(
        .CLK_FREQ (16),
        .BAUD     (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_i        (rx),
        .upg_wen_o   (upg_wen_o),
        .upg_adr_o   (upg_adr_o),
        .upg_dat_o   (upg_dat_o),
        .upg_done_o  (upg_done_o),
        .frame_err_o (frame_err_o)
    );

    always #5 clk = ~clk;

    // Record every write strobe, sampled on the falling edge
    always @(negedge clk) begin
        if (upg_wen_o === 1'b1) begin
            wr_adr.push_back(upg_adr_o);
            wr_dat.push_back(upg_dat_o);
            if (wen_prev) wen_long++;
        end
        wen_prev = (upg_wen_o === 1'b1);
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        rx = stop_bit;
        repeat (DIV) @(negedge clk);
        rx = 1'b1;
        repeat (2 * DIV) @(negedge clk);
    endtask

    task automatic clear_log();
        wr_adr.delete();
        wr_dat.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        rx  = 1'b1;
        repeat (5) @(negedge clk);
        total++; if (upg_done_o !== 1'b1) begin bad++; $display("FAIL reset_done got=%b want=1", upg_done_o); end
        total++; if (upg_wen_o !== 1'b0) begin bad++; $display("FAIL reset_wen got=%b want=0", upg_wen_o); end
        total++; if (upg_adr_o !== 15'h0000) begin bad++; $display("FAIL reset_adr got=%h want=0000", upg_adr_o); end
        total++; if (upg_dat_o !== 32'h0) begin bad++; $display("FAIL reset_dat got=%h want=00000000", upg_dat_o); end
        total++; if (frame_err_o !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b want=0", frame_err_o); end
        rst = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_imem();
        logic [7:0] w0[6] = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        logic [7:0] w1[4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        clear_log();
        send_byte(8'h01, 1'b1);
        total++; if (upg_done_o !== 1'b0) begin bad++; $display("FAIL imem_done_fall got=%b want=0", upg_done_o); end
        foreach (w0[i]) send_byte(w0[i], 1'b1);
        total++;
        if (wr_adr.size() != 1 || wr_adr[0] !== 15'h0000 || wr_dat[0] !== 32'h12345678) begin
            bad++;
            $display("FAIL imem_write0 got n=%0d adr=%h dat=%h want n=1 adr=0000 dat=12345678",
                     wr_adr.size(), (wr_adr.size() > 0) ? wr_adr[0] : 15'h7fff,
                     (wr_dat.size() > 0) ? wr_dat[0] : 32'hx);
        end
        foreach (w1[i]) send_byte(w1[i], 1'b1);
        total++;
        if (wr_adr.size() != 2 || wr_adr[1] !== 15'h0001 || wr_dat[1] !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL imem_write1 got n=%0d adr=%h dat=%h want n=2 adr=0001 dat=deadbeef",
                     wr_adr.size(), (wr_adr.size() > 1) ? wr_adr[1] : 15'h7fff,
                     (wr_dat.size() > 1) ? wr_dat[1] : 32'hx);
        end
        total++; if (upg_done_o !== 1'b0) begin bad++; $display("FAIL imem_done_held got=%b want=0", upg_done_o); end
        total++; if (upg_adr_o !== 15'h0001 || upg_dat_o !== 32'hDEADBEEF) begin
            bad++; $display("FAIL imem_hold got adr=%h dat=%h want adr=0001 dat=deadbeef", upg_adr_o, upg_dat_o);
        end
        send_byte(8'h03, 1'b1);
        total++; if (upg_done_o !== 1'b1) begin bad++; $display("FAIL imem_done_rise got=%b want=1", upg_done_o); end
        total++; if (wen_long != 0) begin bad++; $display("FAIL imem_wen_width got=%0d long pulses want=0", wen_long); end
    endtask

    task automatic test_dmem();
        logic [7:0] seq[7] = '{8'h02, 8'h01, 8'h00, 8'h03, 8'h02, 8'h01, 8'hAA};
        clear_log();
        foreach (seq[i]) send_byte(seq[i], 1'b1);
        total++;
        if (wr_adr.size() != 1 || wr_adr[0] !== 15'h4000 || wr_dat[0] !== 32'hAA010203) begin
            bad++;
            $display("FAIL dmem_write got n=%0d adr=%h dat=%h want n=1 adr=4000 dat=aa010203",
                     wr_adr.size(), (wr_adr.size() > 0) ? wr_adr[0] : 15'h7fff,
                     (wr_dat.size() > 0) ? wr_dat[0] : 32'hx);
        end
        total++; if (upg_done_o !== 1'b0) begin bad++; $display("FAIL dmem_done_held got=%b want=0", upg_done_o); end
        send_byte(8'h03, 1'b1);
        total++; if (upg_done_o !== 1'b1) begin bad++; $display("FAIL dmem_done_rise got=%b want=1", upg_done_o); end
    endtask

    task automatic test_frame_err();
        logic [7:0] pre[5] = '{8'h01, 8'h01, 8'h00, 8'h11, 8'h22};
        logic [7:0] wd[6]  = '{8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
        clear_log();
        foreach (pre[i]) send_byte(pre[i], 1'b1);
        send_byte(8'h33, 1'b0);
        total++; if (frame_err_o !== 1'b1) begin bad++; $display("FAIL ferr_set got=%b want=1", frame_err_o); end
        total++; if (wr_adr.size() != 0) begin bad++; $display("FAIL ferr_nowrite got=%0d writes want=0", wr_adr.size()); end
        total++; if (upg_done_o !== 1'b0) begin bad++; $display("FAIL ferr_done got=%b want=0", upg_done_o); end
        send_byte(8'h01, 1'b1);
        total++; if (frame_err_o !== 1'b0) begin bad++; $display("FAIL ferr_clear got=%b want=0", frame_err_o); end
        // A 0x01 treated as a command proves the FSM had returned to IDLE
        foreach (wd[i]) send_byte(wd[i], 1'b1);
        total++;
        if (wr_adr.size() != 1 || wr_adr[0] !== 15'h0000 || wr_dat[0] !== 32'h11223344) begin
            bad++;
            $display("FAIL ferr_recover got n=%0d adr=%h dat=%h want n=1 adr=0000 dat=11223344",
                     wr_adr.size(), (wr_adr.size() > 0) ? wr_adr[0] : 15'h7fff,
                     (wr_dat.size() > 0) ? wr_dat[0] : 32'hx);
        end
        send_byte(8'h03, 1'b1);
        send_byte(8'h55, 1'b0);
        total++; if (frame_err_o !== 1'b1 || upg_done_o !== 1'b1) begin
            bad++; $display("FAIL ferr_idle got ferr=%b done=%b want ferr=1 done=1", frame_err_o, upg_done_o);
        end
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h03, 1'b1);
        total++; if (frame_err_o !== 1'b0 || upg_done_o !== 1'b1) begin
            bad++; $display("FAIL ferr_dmem_clear got ferr=%b done=%b want ferr=0 done=1", frame_err_o, upg_done_o);
        end
    endtask

    task automatic test_glitch();
        clear_log();
        @(negedge clk);
        rx = 1'b0;
        repeat (DIV / 4) @(negedge clk);
        rx = 1'b1;
        repeat (4 * DIV) @(negedge clk);
        total++; if (wr_adr.size() != 0 || upg_done_o !== 1'b1 || frame_err_o !== 1'b0) begin
            bad++; $display("FAIL glitch got writes=%0d done=%b ferr=%b want 0/1/0", wr_adr.size(), upg_done_o, frame_err_o);
        end
    endtask

    task automatic test_zero_len();
        clear_log();
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        total++; if (upg_done_o !== 1'b0) begin bad++; $display("FAIL zlen_done_low got=%b want=0", upg_done_o); end
        send_byte(8'h03, 1'b1);
        total++; if (upg_done_o !== 1'b1 || wr_adr.size() != 0) begin
            bad++; $display("FAIL zlen_end got done=%b writes=%0d want done=1 writes=0", upg_done_o, wr_adr.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] seq[5] = '{8'h01, 8'h04, 8'h00, 8'hAA, 8'hBB};
        clear_log();
        foreach (seq[i]) send_byte(seq[i], 1'b1);
        total++; if (upg_done_o !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", upg_done_o); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (upg_done_o !== 1'b1 || upg_wen_o !== 1'b0 || upg_adr_o !== 15'h0 || upg_dat_o !== 32'h0 || frame_err_o !== 1'b0) begin
            bad++; $display("FAIL rmid_reset got done=%b wen=%b adr=%h dat=%h ferr=%b want 1/0/0000/00000000/0",
                            upg_done_o, upg_wen_o, upg_adr_o, upg_dat_o, frame_err_o);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        send_byte(8'hCC, 1'b1);
        send_byte(8'hDD, 1'b1);
        total++; if (wr_adr.size() != 0 || upg_done_o !== 1'b1) begin
            bad++; $display("FAIL rmid_nowrite got writes=%0d done=%b want writes=0 done=1", wr_adr.size(), upg_done_o);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] hdr[3] = '{8'h01, 8'h02, 8'h00};
        logic [7:0] wd[8]  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        clear_log();
        foreach (hdr[i]) send_byte(hdr[i], 1'b1);
        @(negedge clk);
        force dut.addr_q = 14'h3FFF;
        @(negedge clk);
        release dut.addr_q;
        foreach (wd[i]) send_byte(wd[i], 1'b1);
        total++;
        if (wr_adr.size() != 2 || wr_adr[0] !== 15'h3FFF || wr_dat[0] !== 32'h04030201) begin
            bad++;
            $display("FAIL wrap_first got n=%0d adr=%h dat=%h want n=2 adr=3fff dat=04030201",
                     wr_adr.size(), (wr_adr.size() > 0) ? wr_adr[0] : 15'h7fff,
                     (wr_dat.size() > 0) ? wr_dat[0] : 32'hx);
        end
        total++;
        if (wr_adr.size() != 2 || wr_adr[1] !== 15'h0000 || wr_dat[1] !== 32'h08070605) begin
            bad++;
            $display("FAIL wrap_second got n=%0d adr=%h dat=%h want n=2 adr=0000 dat=08070605",
                     wr_adr.size(), (wr_adr.size() > 1) ? wr_adr[1] : 15'h7fff,
                     (wr_dat.size() > 1) ? wr_dat[1] : 32'hx);
        end
        send_byte(8'h03, 1'b1);
        total++; if (upg_done_o !== 1'b1) begin bad++; $display("FAIL wrap_done got=%b want=1", upg_done_o); end
    endtask

    initial begin
        test_reset();
        test_imem();
        test_dmem();
        test_frame_err();
        test_glitch();
        test_zero_len();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_programmer.md
Name: uart_programmer

Overview:
- Upstream loader for the single-cycle RISC-V core.
- Receives a byte stream on the board UART RX pin and assembles 32-bit little-endian words.
- Drives the upg_* write port of instruction ROM (bank 0) and data RAM (bank 1).
- Holds upg_done_o low while a download is in progress, which keeps the core out of normal operation.

Parameters:
- CLK_FREQ, 10000000: input clock frequency in Hz (the uart_clk output of the clocking wizard).
- BAUD, 115200: UART bit rate. DIV = CLK_FREQ/BAUD, rounded to nearest, minimum 4.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- rx_i  in  1  UART RX line, idle high, 8N1, LSB first, asynchronous to clk.
- upg_wen_o  out  1  one-cycle write strobe.
- upg_adr_o  out  15  bit14 = bank (0 imem, 1 dmem); bits[13:0] = word address.
- upg_dat_o  out  32  write data word.
- upg_done_o  out  1  1 = no download active (core runs); 0 = programming.
- frame_err_o  out  1  sticky framing/abort error flag.

Behaviour:
- Reset values: upg_wen_o=0, upg_adr_o=0, upg_dat_o=0, upg_done_o=1, frame_err_o=0. Both FSMs return to IDLE. Reset mid-download discards any partial word and produces no write.
- Receiver:
  - rx_i passes through a 2-FF synchroniser, reset to 1.
  - IDLE waits for a synchronised 0, then counts DIV/2 cycles and re-samples. If the line reads 1, it is a false start: return to IDLE.
  - Otherwise it samples 8 data bits at DIV-cycle intervals, then the stop bit after a further DIV.
  - Stop bit = 1: byte_valid pulses for one cycle with the byte.
  - Stop bit = 0: byte_err pulses for one cycle and the byte is discarded.
  - The receiver is back in IDLE in the cycle after the stop sample and accepts a start bit immediately.
- Protocol FSM states: IDLE, LEN_LO, LEN_HI, DATA, WRITE.
  - IDLE, byte 0x01: bank=0, address counter=0, upg_done_o=0, frame_err_o=0, go to LEN_LO.
  - IDLE, byte 0x02: same as 0x01 with bank=1.
  - IDLE, byte 0x03: upg_done_o=1, stay in IDLE.
  - IDLE, any other byte: ignored.
  - LEN_LO then LEN_HI: capture a 16-bit word count N, low byte first. If N=0, return to IDLE with done still 0.
  - DATA: the byte index (0..3) fills dat[8*i+7:8*i]. The 4th byte moves to WRITE in the next cycle. In DATA, bytes 0x01/0x02/0x03 are plain data.
  - WRITE: exactly one cycle with upg_wen_o=1, upg_adr_o={bank, addr}, upg_dat_o=word. Then addr increments (14-bit wrap 0x3FFF->0x0000, bank unchanged) and the remaining count decrements.
  - After WRITE: remaining=0 goes to IDLE, otherwise to DATA.
  - A write occurs DIV-independent, exactly 1 cycle after byte_valid of the 4th byte.
  - upg_adr_o and upg_dat_o hold their last values between strobes.
- Errors:
  - byte_err in LEN_LO, LEN_HI or DATA: frame_err_o=1, partial word dropped, no write, go to IDLE, upg_done_o stays 0.
  - byte_err in IDLE: sets frame_err_o only.
  - frame_err_o clears only on reset or on a 0x01/0x02 command.
- Simultaneous events: a byte arriving during WRITE cannot occur (WRITE lasts 1 cycle, bytes are at least 10*DIV apart). No write-back pressure exists, so there is no handshake.

Decomposition:
- Shared package/header holds:
  - command constants CMD_IMEM=8'h01, CMD_DMEM=8'h02, CMD_DONE=8'h03
  - bank select bit index 14
  - protocol FSM state encodings
- Sub-module uart_rx (ports: clk, rst, rx_i, byte_o[7:0], byte_valid_o, byte_err_o, parameter DIV). It contains the synchroniser, its own IDLE/START/DATA/STOP FSM and the bit/baud counters.
- uart_programmer contains the protocol FSM, word assembly, address and length counters.

Test Plan:
- Reset (CLK_FREQ=16, BAUD=1, DIV=16): hold rst=0 -> upg_done_o=1, upg_wen_o=0, upg_adr_o=0, upg_dat_o=0, frame_err_o=0.
- imem load: send 01 02 00 78 56 34 12 EF BE AD DE 03 -> upg_done_o falls after byte 0x01. upg_wen_o pulses twice: adr 0x0000/dat 0x12345678, then adr 0x0001/dat 0xDEADBEEF. upg_done_o=1 after 0x03.
- dmem load with command-like data: send 02 01 00 03 02 01 AA 03 -> one write, adr 0x4000, dat 0xAA010203. upg_done_o rises only after the final 0x03.
- Framing error: send 01 01 00 11 22, then a byte with stop bit 0 -> frame_err_o=1, no upg_wen_o, FSM in IDLE. A following 01 clears frame_err_o.
- Noise and reset: 0.25*DIV low glitch on rx_i -> no byte, no state change. In a separate run, assert rst after 2 data bytes -> all outputs return to reset values, no write.
- Edge counts: send 01 00 00 03 -> no write, done 1->0->1. Address wrap: start a load with the address counter at 0x3FFF, send 2 words -> writes at 0x3FFF then 0x0000.
